// File: rtl/bus_target_arb_pkg.sv
// rtl/bus_target_arb_pkg.sv - shared state type, command codes and DSP mailbox map
package bus_pkg;

  typedef enum logic [2:0] {
    BS_IDLE      = 3'd0,
    BS_GRANT     = 3'd1,
    BS_ADDR_WAIT = 3'd2,
    BS_DATA      = 3'd3,
    BS_RESP      = 3'd4,
    BS_TURN      = 3'd5
  } bus_state_e;

  localparam logic CMD_READ  = 1'b0;
  localparam logic CMD_WRITE = 1'b1;

  localparam logic [31:0] DSP_FLAG  = 32'h0000_0220;
  localparam logic [31:0] DSP_A     = 32'h0000_0221;
  localparam logic [31:0] DSP_B     = 32'h0000_0223;
  localparam logic [31:0] DSP_X     = 32'h0000_0225;
  localparam logic [31:0] DSP_BEGIN = 32'h0000_0001;
  localparam logic [31:0] DSP_END   = 32'hFFFF_FFFF;

endpackage

// File: rtl/bus_target_arb_if.sv
// rtl/bus_target_arb_if.sv - shared-bus request/grant and handshake lines
interface bus_target_arb_if #(
  parameter int NUM_MASTERS = 2
);
  logic [NUM_MASTERS-1:0] REQ_B;
  logic [NUM_MASTERS-1:0] GNT_B;
  logic                   FRAME_B;
  logic                   CMD;
  logic                   IRDY_B;
  logic                   TRDY_B;

  modport master (output REQ_B, FRAME_B, CMD, IRDY_B, input GNT_B, TRDY_B);
  modport slave  (input REQ_B, FRAME_B, CMD, IRDY_B, output GNT_B, TRDY_B);
endinterface

// File: rtl/bus_target_arb_rr_arbiter.sv
// rtl/bus_target_arb_rr_arbiter.sv - round-robin pick with registered one-hot grant
module rr_arbiter #(
  parameter  int N  = 2,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         load,
  input  logic         clear,
  output logic [N-1:0] gnt,
  output logic         any
);
  logic [PW-1:0] ptr;
  logic [PW-1:0] pick;
  logic [PW-1:0] cand;

  // First requester at or after the pointer, wrapping around.
  always_comb begin
    any  = 1'b0;
    pick = '0;
    cand = '0;
    for (int k = 0; k < N; k++) begin
      cand = PW'((int'(ptr) + k) % N);
      if (!any && req[cand]) begin
        any  = 1'b1;
        pick = cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gnt <= '0;
      ptr <= '0;
    end else if (clear) begin
      gnt <= '0;
    end else if (load && any) begin
      gnt <= N'(1) << pick;
      ptr <= PW'((int'(pick) + 1) % N);
    end
  end
endmodule

// File: rtl/bus_target_arb.sv
// rtl/bus_target_arb.sv - arbitrating shared-bus target in front of the DSP mailbox RAM
module bus_target_arb
  import bus_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int BASE_ADDR   = 'h200,
  parameter int DEPTH       = 64,
  parameter int WAIT_STATES = 0,
  parameter int GNT_TIMEOUT = 16
) (
  input  logic                     CLK,
  input  logic                     RST,
  inout  wire  [31:0]              AD,
  bus_target_arb_if.slave          bus,
  input  logic                     host_en,
  input  logic                     host_we,
  input  logic [$clog2(DEPTH)-1:0] host_addr,
  input  logic [31:0]              host_wdata,
  output logic [31:0]              host_rdata,
  output logic                     busy,
  output logic [7:0]               err_cnt
);
  localparam int          AW = $clog2(DEPTH);
  localparam logic [31:0] LO = 32'(BASE_ADDR);
  localparam logic [31:0] HI = 32'(BASE_ADDR + DEPTH);

  localparam logic [2:0] S_IDLE  = BS_IDLE;
  localparam logic [2:0] S_GRANT = BS_GRANT;
  localparam logic [2:0] S_DATA  = BS_DATA;
  localparam logic [2:0] S_RESP  = BS_RESP;
  localparam logic [2:0] S_TURN  = BS_TURN;

  logic [2:0]             state;
  logic [15:0]            tmo_cnt;
  logic [3:0]             ws_cnt;
  logic                   irdy_seen;
  logic [31:0]            addr_q, wdata_q, ad_q;
  logic                   cmd_q, ad_oe, trdy_q;
  logic [31:0]            mem [DEPTH];
  logic [NUM_MASTERS-1:0] req_hi, gnt;
  logic                   any_req, frame_low, irdy_low, tmo_done, go_resp, grant_clr, in_range;
  logic [AW-1:0]          bus_idx;

  // Floating or high lines never count as asserted.
  always_comb begin
    req_hi = '0;
    for (int i = 0; i < NUM_MASTERS; i++) req_hi[i] = (bus.REQ_B[i] === 1'b0);
  end

  assign frame_low = (bus.FRAME_B === 1'b0);
  assign irdy_low  = (bus.IRDY_B === 1'b0);
  assign tmo_done  = (tmo_cnt == 16'(GNT_TIMEOUT - 1));
  assign in_range  = (addr_q >= LO) && (addr_q < HI);
  assign bus_idx   = AW'(addr_q - LO);
  assign grant_clr = (state == S_GRANT) && (frame_low || tmo_done);
  assign go_resp   = (state == S_DATA) &&
                     (irdy_seen ? (ws_cnt == 4'(WAIT_STATES)) : (irdy_low && WAIT_STATES == 0));

  rr_arbiter #(.N(NUM_MASTERS)) u_arb (
    .clk   (CLK),
    .rst   (RST),
    .req   (req_hi),
    .load  (state == S_IDLE),
    .clear (grant_clr),
    .gnt   (gnt),
    .any   (any_req)
  );

  assign bus.GNT_B  = ~gnt;
  assign bus.TRDY_B = trdy_q;
  assign AD         = ad_oe ? ad_q : 'z;
  assign busy       = (state != S_IDLE);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= S_IDLE;
      tmo_cnt   <= '0;
      ws_cnt    <= '0;
      irdy_seen <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      cmd_q     <= CMD_READ;
      trdy_q    <= 1'b1;
      ad_oe     <= 1'b0;
      ad_q      <= '0;
      err_cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: if (any_req) begin
          state   <= S_GRANT;
          tmo_cnt <= '0;
        end
        S_GRANT: if (frame_low) begin
          addr_q <= AD;
          cmd_q  <= (bus.CMD === 1'b1) ? CMD_WRITE : CMD_READ;
          state  <= S_DATA;
        end else if (tmo_done) begin
          state <= S_IDLE;
        end else begin
          tmo_cnt <= tmo_cnt + 16'd1;
        end
        S_DATA: if (go_resp) begin
          state     <= S_RESP;
          trdy_q    <= 1'b0;
          irdy_seen <= 1'b0;
          if (cmd_q == CMD_WRITE) begin
            wdata_q <= AD;
          end else begin
            ad_oe <= 1'b1;
            ad_q  <= in_range ? mem[bus_idx] : '0;
          end
        end else if (irdy_seen) begin
          ws_cnt <= ws_cnt + 4'd1;
        end else if (irdy_low) begin
          irdy_seen <= 1'b1;
          ws_cnt    <= 4'd1;
        end
        S_RESP: begin
          trdy_q <= 1'b1;
          ad_oe  <= 1'b0;
          state  <= S_TURN;
          if (!in_range && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
        end
        S_TURN:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Bus write is ordered after the host write so it wins on a same-word collision.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      host_rdata <= '0;
    end else begin
      if (host_en) begin
        host_rdata <= mem[host_addr];
        if (host_we) mem[host_addr] <= host_wdata;
      end
      if (state == S_RESP && cmd_q == CMD_WRITE && in_range) mem[bus_idx] <= wdata_q;
    end
  end
endmodule

// File: tb/tb_bus_target_arb.sv
// tb/tb_bus_target_arb.sv - directed and randomized bench for bus_target_arb against a behavioural model
module tb_bus_target_arb;
  import bus_pkg::*;

  localparam int N = 2;
  localparam logic [N-1:0] NONE = '1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sel = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0] req_b   = '1;
  logic         frame_b = 1'b1;
  logic         cmd     = 1'b0;
  logic         irdy_b  = 1'b1;
  logic [31:0]  ad_drv  = '0;
  logic         ad_oe   = 1'b0;
  wire  [31:0]  ad0, ad1;
  assign ad0 = ad_oe ? ad_drv : 'z;
  assign ad1 = ad_oe ? ad_drv : 'z;

  logic        host_en = 1'b0, host_we = 1'b0;
  logic [5:0]  host_addr = '0;
  logic [31:0] host_wdata = '0;
  logic [31:0] hrd0, hrd1;
  logic        busy0, busy1;
  logic [7:0]  err0, err1;

  bus_target_arb_if #(.NUM_MASTERS(N)) bif0 ();
  bus_target_arb_if #(.NUM_MASTERS(N)) bif1 ();
  assign bif0.REQ_B = req_b;   assign bif1.REQ_B = req_b;
  assign bif0.FRAME_B = frame_b; assign bif1.FRAME_B = frame_b;
  assign bif0.CMD = cmd;       assign bif1.CMD = cmd;
  assign bif0.IRDY_B = irdy_b; assign bif1.IRDY_B = irdy_b;

  bus_target_arb #(.NUM_MASTERS(N), .WAIT_STATES(0)) u_dut0 (
    .CLK(clk), .RST(rst | sel), .AD(ad0), .bus(bif0),
    .host_en(host_en), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_rdata(hrd0), .busy(busy0), .err_cnt(err0));

  bus_target_arb #(.NUM_MASTERS(N), .WAIT_STATES(3)) u_dut1 (
    .CLK(clk), .RST(rst | ~sel), .AD(ad1), .bus(bif1),
    .host_en(host_en), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_rdata(hrd1), .busy(busy1), .err_cnt(err1));

  logic [N-1:0] gnt_b;
  logic         trdy_b, busy_o;
  logic [7:0]   err_o;
  logic [31:0]  hrd_o, ad_o;
  assign gnt_b  = sel ? bif1.GNT_B  : bif0.GNT_B;
  assign trdy_b = sel ? bif1.TRDY_B : bif0.TRDY_B;
  assign busy_o = sel ? busy1 : busy0;
  assign err_o  = sel ? err1  : err0;
  assign hrd_o  = sel ? hrd1  : hrd0;
  assign ad_o   = sel ? ad1   : ad0;

  logic [31:0] mem_m [64];
  int err_m = 0, ptr_m = 0, ws = 0;
  int checks = 0, passed = 0, fails = 0;
  bit overlap = 1'b0;

  always @(negedge clk) if (!rst && $countones(~gnt_b) > 1) overlap = 1'b1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 64; i++) mem_m[i] = '0;
    err_m = 0;
    ptr_m = 0;
  endtask

  function automatic int rr_pick(input logic [N-1:0] mask, input int p);
    for (int k = 0; k < N; k++) if (mask[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  function automatic bit in_rng(input logic [31:0] a);
    return (a >= 32'h200) && (a < 32'h240);
  endfunction

  task automatic host_write(input int idx, input logic [31:0] d);
    logic [31:0] old;
    old = mem_m[idx];
    host_en = 1'b1; host_we = 1'b1; host_addr = 6'(idx); host_wdata = d;
    tick();
    host_en = 1'b0; host_we = 1'b0;
    mem_m[idx] = d;
    check("host_rdw_old", hrd_o, old);
  endtask

  task automatic host_read(input string tag, input int idx);
    host_en = 1'b1; host_we = 1'b0; host_addr = 6'(idx);
    tick();
    host_en = 1'b0;
    check(tag, hrd_o, mem_m[idx]);
  endtask

  task automatic xfer(input logic [N-1:0] mask, input bit wr, input logic [31:0] addr,
                      input logic [31:0] data, input bit hold);
    int exp_m, lat, idx;
    logic [N-1:0] eg;
    logic [31:0] exp_rd;
    exp_m = rr_pick(mask, ptr_m);
    eg = NONE;
    eg[exp_m] = 1'b0;
    req_b = ~mask;
    lat = 0;
    do begin tick(); lat++; end while (gnt_b === NONE && lat < 20);
    check("gnt_latency", lat, 1);
    check("gnt_owner", gnt_b, eg);
    ptr_m = (exp_m + 1) % N;
    frame_b = 1'b0; cmd = wr; ad_drv = addr; ad_oe = 1'b1;
    tick();
    check("gnt_release", gnt_b, NONE);
    frame_b = 1'b1; irdy_b = 1'b0;
    if (wr) ad_drv = data; else ad_oe = 1'b0;
    lat = 0;
    do begin tick(); lat++; end while (trdy_b !== 1'b0 && lat < 40);
    check("trdy_latency", lat, ws + 1);
    idx = int'(addr - 32'h200);
    if (in_rng(addr)) begin
      if (wr) mem_m[idx] = data;
      exp_rd = mem_m[idx];
    end else begin
      exp_rd = '0;
      if (err_m < 255) err_m++;
    end
    if (!wr) check("read_data", ad_o, exp_rd);
    irdy_b = 1'b1; ad_oe = 1'b0;
    if (!hold) req_b = NONE;
    tick();
    check("trdy_one_cycle", trdy_b, 1'b1);
    ad_drv = '0; ad_oe = 1'b1;
    #1;
    check("ad_released", ad_o, 32'h0);
    ad_oe = 1'b0;
    check("err_cnt", err_o, err_m);
    tick();
  endtask

  initial begin
    int cnt;
    logic [31:0] a;
    do_reset();
    check("rst_gnt", gnt_b, NONE);
    check("rst_trdy", trdy_b, 1'b1);
    check("rst_busy", busy_o, 1'b0);
    check("rst_err", err_o, 8'h0);
    check("rst_hrdata", hrd_o, 32'h0);

    host_write(int'(DSP_FLAG - 32'h200), DSP_BEGIN);
    host_write(int'(DSP_A - 32'h200), 32'h0000_0005);
    host_write(int'(DSP_B - 32'h200), 32'h0000_0007);

    overlap = 1'b0;
    xfer(2'b11, 1'b0, DSP_FLAG, '0, 1'b1);
    xfer(2'b11, 1'b0, DSP_A, '0, 1'b1);
    xfer(2'b11, 1'b0, DSP_B, '0, 1'b0);
    check("no_overlap", overlap, 1'b0);

    xfer(2'b10, 1'b0, 32'h300, '0, 1'b0);
    xfer(2'b10, 1'b1, 32'h1FF, 32'h1234_5678, 1'b0);
    host_read("oor_idx00", 0);
    host_read("oor_idx3f", 63);

    req_b = 2'b10;
    cnt = 0;
    do begin tick(); cnt++; end while (gnt_b === NONE && cnt < 20);
    check("tmo_gnt0", gnt_b, 2'b10);
    check("busy_grant", busy_o, 1'b1);
    ptr_m = 1;
    req_b = 2'b01;
    cnt = 0;
    while (gnt_b !== NONE && cnt < 40) begin cnt++; tick(); end
    check("gnt_timeout0", cnt, 16);
    tick();
    check("next_grant", gnt_b, 2'b01);
    ptr_m = 0;
    req_b = NONE;
    cnt = 0;
    while (gnt_b !== NONE && cnt < 40) begin cnt++; tick(); end
    check("gnt_timeout1", cnt, 16);
    tick();
    check("idle_after_tmo", busy_o, 1'b0);

    for (int t = 0; t < 30; t++) begin
      case ($urandom_range(0, 5))
        0: a = 32'h1FF;
        1: a = 32'h240;
        2: a = 32'h8000_0200 + $urandom_range(0, 63);
        default: a = 32'h200 + $urandom_range(0, 63);
      endcase
      if ($urandom_range(0, 3) == 0) host_write($urandom_range(0, 63), $urandom);
      xfer(N'($urandom_range(1, 3)), 1'($urandom_range(0, 1)), a, $urandom, 1'b0);
    end
    for (int t = 0; t < 8; t++) host_read("rand_host_rd", $urandom_range(0, 63));

    sel = 1'b1;
    ws = 3;
    do_reset();
    xfer(2'b01, 1'b1, DSP_X, 32'hFFFF_FFF6, 1'b0);
    host_read("ws3_dsp_x", int'(DSP_X - 32'h200));
    for (int t = 0; t < 8; t++)
      xfer(N'($urandom_range(1, 3)), 1'($urandom_range(0, 1)),
           32'h200 + $urandom_range(0, 63), $urandom, 1'b0);

    do_reset();
    req_b = 2'b10;
    tick();
    check("rst_test_gnt", gnt_b, 2'b10);
    frame_b = 1'b0; cmd = 1'b1; ad_drv = DSP_A; ad_oe = 1'b1;
    tick();
    frame_b = 1'b1; irdy_b = 1'b0; ad_drv = 32'hDEAD_BEEF;
    cnt = 0;
    do begin tick(); cnt++; end while (trdy_b !== 1'b0 && cnt < 40);
    check("rst_test_resp", trdy_b, 1'b0);
    rst = 1'b1; req_b = NONE;
    tick();
    check("midrst_trdy", trdy_b, 1'b1);
    check("midrst_gnt", gnt_b, NONE);
    check("midrst_busy", busy_o, 1'b0);
    check("midrst_ad", ad_o, 32'hDEAD_BEEF);
    rst = 1'b0; irdy_b = 1'b1; ad_oe = 1'b0;
    for (int i = 0; i < 64; i++) mem_m[i] = '0;
    err_m = 0;
    ptr_m = 0;
    host_read("midrst_no_commit", int'(DSP_A - 32'h200));
    check("midrst_err", err_o, 8'h0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
